// File: rtl/fp_fma_wb_tracker_pkg.sv
// Shared constants for the FMA writeback tracker: datapath widths and FMA pipe depth.
package fp_fma_wb_tracker_pkg;

  localparam int unsigned FPR_RECODED_WIDTH = 65;
  localparam int unsigned FPU_EXC_WIDTH     = 5;
  localparam int unsigned FMA_PIPE_DEPTH    = 4;

  // Register stages between operand presentation and result for a given pipe depth.
  function automatic int unsigned fma_shadow_lat(input int unsigned depth);
    return (depth > 1) ? depth - 1 : 1;
  endfunction

endpackage

// File: rtl/fp_wb_fifo.sv
// Synchronous FIFO with async active-high reset; wrap-bit pointers give full/empty/count.
module fp_wb_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned PW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [PW-1:0]    count
);

  localparam int unsigned   AWI  = (AW == 0) ? 1 : AW;
  localparam logic [PW-1:0] WRAP = PW'(1) << AW;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AWI-1:0]   wr_addr, rd_addr;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // A single-entry FIFO has only the wrap bit, so its storage address is constant.
  generate
    if (AW == 0) begin : g_single
      assign wr_addr = '0;
      assign rd_addr = '0;
    end else begin : g_multi
      assign wr_addr = wr_ptr_q[AWI-1:0];
      assign rd_addr = rd_ptr_q[AWI-1:0];
    end
  endgenerate

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_addr] <= wdata;
  end

  assign rdata = mem_q[rd_addr];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = ((wr_ptr_q ^ rd_ptr_q) == WRAP);
  assign count = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/fp_fma_wb_tracker.sv
// Writeback tracker for the fixed-latency FMA pipe: shadows dest tags, buffers results,
// and drives the FPR writeback port with credit backpressure and a per-register pending mask.
module fp_fma_wb_tracker
  import fp_fma_wb_tracker_pkg::*;
#(
  parameter int unsigned PIPE_LAT   = fma_shadow_lat(FMA_PIPE_DEPTH),
  parameter int unsigned TAG_W      = 5,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = FPR_RECODED_WIDTH,
  parameter int unsigned EXC_W      = FPU_EXC_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_val,
  output logic                    issue_rdy,
  input  logic [TAG_W-1:0]        issue_tag,
  input  logic [DATA_W-1:0]       fma_result,
  input  logic [EXC_W-1:0]        fma_exc,
  output logic                    wb_val,
  input  logic                    wb_rdy,
  output logic [TAG_W-1:0]        wb_tag,
  output logic [DATA_W-1:0]       wb_data,
  output logic [EXC_W-1:0]        wb_exc,
  output logic [(2**TAG_W)-1:0]   pending
);

  localparam int unsigned NREG    = 2 ** TAG_W;
  localparam int unsigned ENTRY_W = TAG_W + DATA_W + EXC_W;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic                  issue_fire;
  logic                  wb_fire;

  logic [PIPE_LAT-1:0]   sh_val_q, sh_val_d;
  logic [TAG_W-1:0]      sh_tag_q [PIPE_LAT];
  logic [TAG_W-1:0]      sh_tag_d [PIPE_LAT];
  logic                  sh_out_val;
  logic [TAG_W-1:0]      sh_out_tag;

  logic [CNT_W-1:0]      count_q, count_d;
  logic [NREG-1:0]       pend_q, pend_d;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic [ENTRY_W-1:0]    fifo_wdata;
  logic [ENTRY_W-1:0]    fifo_head;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [FCNT_W-1:0]     fifo_count;

  // Credits cover every op in the shadow plus every buffered result, so issue never outruns the FIFO.
  assign issue_rdy  = (count_q < CNT_W'(FIFO_DEPTH));
  assign issue_fire = issue_val & issue_rdy;
  assign wb_fire    = wb_val & wb_rdy;

  assign sh_out_val = sh_val_q[PIPE_LAT-1];
  assign sh_out_tag = sh_tag_q[PIPE_LAT-1];

  always_comb begin
    sh_val_d    = sh_val_q;
    sh_val_d[0] = issue_fire;
    sh_tag_d[0] = issue_tag;
    for (int i = 1; i < PIPE_LAT; i++) begin
      sh_val_d[i] = sh_val_q[i-1];
      sh_tag_d[i] = sh_tag_q[i-1];
    end
  end

  // A result may bypass the FIFO only when nothing older is waiting ahead of it.
  always_comb begin
    wb_val    = 1'b0;
    wb_tag    = '0;
    wb_data   = '0;
    wb_exc    = '0;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    if (!fifo_empty) begin
      wb_val                     = 1'b1;
      {wb_tag, wb_data, wb_exc}  = fifo_head;
      fifo_pop                   = wb_rdy;
      fifo_push                  = sh_out_val;
    end else if (sh_out_val) begin
      wb_val    = 1'b1;
      wb_tag    = sh_out_tag;
      wb_data   = fma_result;
      wb_exc    = fma_exc;
      fifo_push = ~wb_rdy;
    end
  end

  assign fifo_wdata = {sh_out_tag, fma_result, fma_exc};

  always_comb begin
    count_d = count_q;
    if (issue_fire && !wb_fire) begin
      count_d = count_q + CNT_W'(1);
    end else if (!issue_fire && wb_fire) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Set is applied after clear so a same-cycle retire and reissue of one register stays pending.
  always_comb begin
    pend_d = pend_q;
    if (wb_fire)    pend_d = pend_d & ~(NREG'(1) << wb_tag);
    if (issue_fire) pend_d = pend_d | (NREG'(1) << issue_tag);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_val_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) sh_tag_q[i] <= '0;
      count_q  <= '0;
      pend_q   <= '0;
    end else begin
      sh_val_q <= sh_val_d;
      for (int i = 0; i < PIPE_LAT; i++) sh_tag_q[i] <= sh_tag_d[i];
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  assign pending = pend_q;

  fp_wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Simulation-only protocol and invariant checks.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(fifo_push && fifo_full))
        else $error("wb fifo overflow attempt");
      assert (!(issue_fire && pend_q[issue_tag] && !(wb_fire && (wb_tag == issue_tag))))
        else $error("WAW issue to pending register %0d", issue_tag);
      assert (32'(count_q) == 32'($countones(sh_val_q)) + 32'(fifo_count))
        else $error("credit count out of step with shadow and fifo occupancy");
    end
  end

endmodule
